// File: rtl/eth_tx_ctrl.sv
// RMII Ethernet frame transmitter: preamble, header, payload, pad, FCS, IFG.
// Sends one dibit per clock on Txd and pulls payload bytes via Data_Rd.
module eth_tx_ctrl #(
  parameter logic [47:0] pDEST_MAC = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] pSRC_MAC  = 48'h020000000001,
  parameter logic [15:0] pLEN_TYPE = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        Tx_Start,
  input  logic [15:0] Tx_Len,
  input  logic [7:0]  Data_Byte,
  input  logic        Data_Valid,
  output logic        Data_Rd,
  output logic [1:0]  Txd,
  output logic        Tx_En,
  output logic        Busy,
  output logic        Done,
  output logic        Underrun
);

  typedef enum logic [3:0] {
    TX_IDLE,
    TX_PREAMBLE,
    TX_DEST,
    TX_SRC,
    TX_LEN_TYPE,
    TX_PAYLOAD,
    TX_PAD,
    TX_FCS,
    TX_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] dib_q, dib_d;
  logic [10:0] byte_q, byte_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] crc_q, crc_d;
  logic [1:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        und_q, und_d;
  logic        byte_end;

  assign byte_end = &dib_q[1:0];

  function automatic logic [1:0] dibit(
    input logic [7:0] b,
    input logic [1:0] d
  );
    logic [7:0] s;
    s = b >> {d, 1'b0};
    return s[1:0];
  endfunction

  function automatic logic [7:0] mac_byte(
    input logic [47:0] m,
    input logic [2:0]  i
  );
    logic [47:0] s;
    s = m >> {3'd5 - i, 3'b000};
    return s[7:0];
  endfunction

  function automatic logic [1:0] fcs_dibit(
    input logic [31:0] c,
    input logic [3:0]  d
  );
    logic [31:0] s;
    s = c >> {d, 1'b0};
    return s[1:0];
  endfunction

  function automatic logic [31:0] crc2(
    input logic [31:0] c,
    input logic [1:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Next state and counters; a failed payload fetch overrides everything.
  always_comb begin
    state_d = state_q;
    dib_d   = dib_q + 11'd1;
    byte_d  = byte_q;
    len_d   = len_q;
    data_d  = data_q;
    done_d  = 1'b0;
    und_d   = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        dib_d  = '0;
        byte_d = '0;
        if (Tx_Start) begin
          state_d = TX_PREAMBLE;
          len_d   = (Tx_Len > 16'd1500) ? 11'd1500 : Tx_Len[10:0];
        end
      end
      TX_PREAMBLE: begin
        if (dib_q == 11'd31) begin
          state_d = TX_DEST;
          dib_d   = '0;
        end
      end
      TX_DEST: begin
        if (byte_end) begin
          dib_d  = '0;
          byte_d = byte_q + 11'd1;
          if (byte_q == 11'd5) begin
            state_d = TX_SRC;
            byte_d  = '0;
          end
        end
      end
      TX_SRC: begin
        if (byte_end) begin
          dib_d  = '0;
          byte_d = byte_q + 11'd1;
          if (byte_q == 11'd5) begin
            state_d = TX_LEN_TYPE;
            byte_d  = '0;
          end
        end
      end
      TX_LEN_TYPE: begin
        if (byte_end) begin
          dib_d  = '0;
          byte_d = byte_q + 11'd1;
          if (byte_q == 11'd1) begin
            state_d = (len_q == '0) ? TX_PAD : TX_PAYLOAD;
            byte_d  = '0;
          end
        end
      end
      TX_PAYLOAD: begin
        if (byte_end) begin
          dib_d  = '0;
          byte_d = byte_q + 11'd1;
          if (byte_q == len_q - 11'd1) begin
            state_d = (len_q < 11'd46) ? TX_PAD : TX_FCS;
            byte_d  = '0;
          end
        end
      end
      TX_PAD: begin
        if (byte_end) begin
          dib_d  = '0;
          byte_d = byte_q + 11'd1;
          if (byte_q == 11'd45 - len_q) begin
            state_d = TX_FCS;
            byte_d  = '0;
          end
        end
      end
      TX_FCS: begin
        if (dib_q == 11'd15) begin
          state_d = TX_IFG;
          dib_d   = '0;
          done_d  = 1'b1;
        end
      end
      TX_IFG: begin
        if (dib_q == 11'd47) begin
          state_d = TX_IDLE;
          dib_d   = '0;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (rd_q) begin
      data_d = Data_Byte;
      if (!Data_Valid) begin
        state_d = TX_IFG;
        dib_d   = '0;
        byte_d  = '0;
        und_d   = 1'b1;
      end
    end
  end

  // Registered-output decode from the upcoming state, plus CRC accumulation.
  always_comb begin
    txd_d = 2'b00;
    en_d  = 1'b0;
    unique case (state_d)
      TX_PREAMBLE: begin
        en_d  = 1'b1;
        txd_d = (dib_d == 11'd31) ? 2'b11 : 2'b01;
      end
      TX_DEST: begin
        en_d  = 1'b1;
        txd_d = dibit(mac_byte(pDEST_MAC, byte_d[2:0]), dib_d[1:0]);
      end
      TX_SRC: begin
        en_d  = 1'b1;
        txd_d = dibit(mac_byte(pSRC_MAC, byte_d[2:0]), dib_d[1:0]);
      end
      TX_LEN_TYPE: begin
        en_d  = 1'b1;
        txd_d = dibit(byte_d[0] ? pLEN_TYPE[7:0] : pLEN_TYPE[15:8],
                      dib_d[1:0]);
      end
      TX_PAYLOAD: begin
        en_d  = 1'b1;
        txd_d = dibit(data_d, dib_d[1:0]);
      end
      TX_PAD: en_d = 1'b1;
      TX_FCS: begin
        en_d  = 1'b1;
        txd_d = fcs_dibit(~crc_q, dib_d[3:0]);
      end
      default: ;
    endcase
    crc_d = crc_q;
    if (state_q == TX_IDLE) crc_d = '1;
    else if (state_d inside {TX_DEST, TX_SRC, TX_LEN_TYPE, TX_PAYLOAD, TX_PAD})
      crc_d = crc2(crc_q, txd_d);
    busy_d = (state_d != TX_IDLE);
    rd_d = (dib_d[1:0] == 2'b11) &&
           (((state_d == TX_LEN_TYPE) && (byte_d == 11'd1) &&
             (len_q != '0)) ||
            ((state_d == TX_PAYLOAD) && (byte_d != len_q - 11'd1)));
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst_N) begin
      state_q <= TX_IDLE;
      dib_q   <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      crc_q   <= '1;
      txd_q   <= 2'b00;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dib_q   <= dib_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      und_q   <= und_d;
    end
  end

  assign Txd      = txd_q;
  assign Tx_En    = en_q;
  assign Data_Rd  = rd_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Underrun = und_q;

endmodule
